fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000: first fetch address after reset.
REQ-002 Parameter DEPTH, default 4: instruction queue entries; power of two, 2..16.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 imem_req_valid  output  1  fetch request valid.
REQ-006 imem_req_ready  input  1  memory accepts the request this cycle.
REQ-007 imem_req_addr  output  32  fetch address; bits [1:0] always 0.
REQ-008 imem_resp_valid  input  1  one response word this cycle; responses return in request order.
REQ-009 imem_resp_data  input  32  instruction word for the oldest outstanding request.
REQ-010 redirect  input  1  branch or jump taken; flush and restart fetch.
REQ-011 redirect_pc  input  32  new fetch address; bits [1:0] ignored and treated as 0.
REQ-012 pause  input  1  decoder saw ECALL/EBREAK/FENCE; halt delivery.
REQ-013 resume  input  1  leave the halted state.
REQ-014 inst_valid  output  1  queue head is presented to the decoder.
REQ-015 inst_ready  input  1  decoder consumes the head this cycle.
REQ-016 inst  output  32  head instruction word.
REQ-017 inst_pc  output  32  address of the head instruction.
REQ-018 halted  output  1  state is HALT.

Function
REQ-019 State machine has two states: RUN and HALT; reset state is RUN.
REQ-020 RUN -> HALT on pause; HALT -> RUN on resume; if pause and resume are both high, pause wins.
REQ-021 imem_req_valid = rst_n && state==RUN && !redirect && (count + outstanding < DEPTH).
REQ-022 The request handshake occurs when imem_req_valid && imem_req_ready: fetch_pc += 4 (mod 2^32), outstanding += 1.
REQ-023 A response with discard == 0 is written to the queue tail together with its pc; it is visible at inst_valid the next cycle (minimum request-to-inst_valid latency is 2 cycles).
REQ-024 A response with discard > 0 is dropped and decrements discard; either kind of response decrements outstanding.
REQ-025 inst_valid = (count > 0) && state==RUN && !redirect; a pop occurs when inst_valid && inst_ready.
REQ-026 Push and pop in the same cycle leave count unchanged; the queue pointers wrap modulo DEPTH.
REQ-027 The rule in REQ-021 guarantees no overflow; a push when count==DEPTH is a design error and is flagged by a simulation assertion.
REQ-028 On redirect (any state):
  - count is cleared to 0.
  - fetch_pc is set to {redirect_pc[31:2], 2'b00}.
  - discard is set to the number of requests still outstanding after this cycle's response is accounted.
  - State is unchanged.
REQ-029 A response arriving in the same cycle as redirect is always dropped.
REQ-030 In HALT, no new requests are issued and inst_valid = 0; in-flight responses are still queued (or discarded per REQ-024).
REQ-031 An all-zero instruction word is queued and delivered unchanged.
REQ-032 The inst and inst_pc values are don't-care when inst_valid = 0.
REQ-033 The outstanding and discard counters saturate-free: width is clog2(DEPTH)+1, neither exceeds DEPTH, and neither underflows (a response with outstanding==0 is a design error and is asserted).

Reset
REQ-034 While rst_n = 0, all outputs are driven as follows:
  - imem_req_valid = 0, inst_valid = 0, halted = 0.
  - imem_req_addr = RESET_PC.
  - state = RUN.
  - count, outstanding and discard = 0.
  - Queue contents are unchanged-irrelevant.
REQ-035 Reset asserted mid-operation aborts all transactions immediately, and responses arriving while in reset are ignored.
REQ-036 After rst_n deasserts, the first request (address RESET_PC) is offered in the first cycle.

Verification
REQ-037 Reset release, memory always ready, 1-cycle response returning words 0x00000013, 0x00100093, ... -> requests at 0x0, 0x4, 0x8, and so on; first inst_valid 2 cycles after the first handshake; inst_pc matches each word.
REQ-038 inst_ready held low with DEPTH=4 -> exactly 4 requests are accepted and imem_req_valid stays 0 until a pop, with no loss and no reordering.
REQ-039 Two requests outstanding, then redirect to 0x00000103 -> next request address is 0x00000100; both late responses are dropped; first delivered inst_pc is 0x100.
REQ-040 pause pulse with 2 entries queued -> halted=1, inst_valid=0, no requests issued; resume -> the same 2 entries are delivered in order, then fetch continues.
REQ-041 Simultaneous redirect and imem_resp_valid, plus pause and resume together -> the response is dropped, state becomes HALT, and the queue is empty.
REQ-042 rst_n pulsed low mid-stream with 3 requests outstanding -> all counters are 0, late responses are ignored, and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues in-order fetch requests, queues the returned words
// with their pcs, and handles redirect flushes and the RUN/HALT delivery gate.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        pause,
    input  logic        resume,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        halted
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic [31:0]      fetch_pc;
    logic [31:0]      resp_pc;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] discard;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [31:0]      mem_data [DEPTH];
    logic [31:0]      mem_pc   [DEPTH];

    logic req_fire;
    logic pop;
    logic push;

    assign req_fire      = imem_req_valid && imem_req_ready;
    assign pop           = inst_valid && inst_ready;
    assign push          = imem_resp_valid && (discard == '0) && !redirect;
    assign imem_req_addr = fetch_pc;
    assign inst          = mem_data[rd_ptr];
    assign inst_pc       = mem_pc[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // pause has priority over resume in either state
    always_comb begin
        state_next = state;
        case (state)
            ST_RUN:  if (pause) state_next = ST_HALT;
            ST_HALT: if (!pause && resume) state_next = ST_RUN;
            default: state_next = ST_RUN;
        endcase
    end

    always_comb begin
        imem_req_valid = 1'b0;
        inst_valid     = 1'b0;
        halted         = 1'b0;
        if (rst_n) begin
            imem_req_valid = (state == ST_RUN) && !redirect &&
                             ((SUM_W'(count) + SUM_W'(outstanding)) < SUM_W'(DEPTH));
            inst_valid     = (count != '0) && (state == ST_RUN) && !redirect;
            halted         = (state == ST_HALT);
        end
    end

    // resp_pc tracks the pc of the next response that will be kept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(imem_resp_valid);
            if (redirect) begin
                fetch_pc <= {redirect_pc[31:2], 2'b00};
                resp_pc  <= {redirect_pc[31:2], 2'b00};
                count    <= '0;
                discard  <= outstanding - CNT_W'(imem_resp_valid);
                wr_ptr   <= '0;
                rd_ptr   <= '0;
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + 32'd4;
                if (push) begin
                    resp_pc <= resp_pc + 32'd4;
                    wr_ptr  <= wr_ptr + PTR_W'(1);
                end
                if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
                count <= count + CNT_W'(push) - CNT_W'(pop);
                if (imem_resp_valid && (discard != '0)) discard <= discard - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= imem_resp_data;
            mem_pc[wr_ptr]   <= resp_pc;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && (count == CNT_W'(DEPTH))));
    a_no_orphan_resp: assert property (@(posedge clk) disable iff (!rst_n)
        !(imem_resp_valid && (outstanding == '0)));

endmodule
